// File: rtl/ins_line_fill.sv
// rtl/ins_line_fill.sv - instruction line fill unit (optional pending-request slot: ILF_PENDING_EN)
module ins_line_fill #(
    parameter int LS_QW_W = 14,
    parameter int PC_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               read_enable,
    input  logic [PC_W-1:0]    line_addr,
    output logic [0:15][0:31]  ins_cache,
    output logic               line_valid,
    output logic               line_done,
    output logic               busy,
    output logic               ls_req,
    output logic [LS_QW_W-1:0] ls_addr,
    input  logic               ls_gnt,
    input  logic               ls_rvalid,
    input  logic [0:127]       ls_rdata
);
    localparam int LA_W = PC_W - 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state, state_next;
    logic [2:0]         issue_cnt, rsp_cnt;
    logic [LS_QW_W-1:0] base_qw;
    logic [LA_W-1:0]    loaded_addr, fill_addr;
    logic [0:11][0:31]  shadow;

    logic [LA_W-1:0]    req_line, restart_addr, load_addr;
    logic               start, restart, load, issue, beat, commit;
    logic               addr_lsb_unused;

    assign req_line        = line_addr[PC_W-1:2];
    assign addr_lsb_unused = ^line_addr[1:0];

    assign busy    = (state == FILL);
    assign ls_req  = (state == FILL) && (issue_cnt < 3'd4);
    assign ls_addr = ls_req ? base_qw + LS_QW_W'(issue_cnt) : '0;

    // A held request for the line already on display must never refetch.
    assign start  = (state == IDLE) && read_enable && (!line_valid || req_line != loaded_addr);
    assign issue  = ls_req && ls_gnt;
    assign beat   = (state == FILL) && ls_rvalid && (rsp_cnt != 3'd4);
    assign commit = beat && (rsp_cnt == 3'd3);

`ifdef ILF_PENDING_EN
    logic            pend_valid;
    logic [LA_W-1:0] pend_addr;
    logic            new_pend;

    // A request arriving in the commit cycle itself still counts as pending.
    assign new_pend     = (state == FILL) && read_enable && (req_line != fill_addr);
    assign restart      = commit && (new_pend || pend_valid);
    assign restart_addr = new_pend ? req_line : pend_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else if (commit) begin
            pend_valid <= 1'b0;
        end else if (new_pend) begin
            pend_valid <= 1'b1;
            pend_addr  <= req_line;
        end
    end
`else
    assign restart      = 1'b0;
    assign restart_addr = fill_addr;
`endif

    assign load      = start || restart;
    assign load_addr = start ? req_line : restart_addr;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (commit && !restart) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            rsp_cnt     <= '0;
            base_qw     <= '0;
            fill_addr   <= '0;
            loaded_addr <= '0;
            shadow      <= '0;
            ins_cache   <= '0;
            line_valid  <= 1'b0;
            line_done   <= 1'b0;
        end else begin
            state     <= state_next;
            line_done <= commit;

            if (load) begin
                base_qw   <= LS_QW_W'(load_addr);
                fill_addr <= load_addr;
                issue_cnt <= '0;
                rsp_cnt   <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + 3'd1;
                if (beat)  rsp_cnt   <= rsp_cnt + 3'd1;
            end

            if (beat && !commit) begin
                case (rsp_cnt[1:0])
                    2'd0:    shadow[0:3]  <= ls_rdata;
                    2'd1:    shadow[4:7]  <= ls_rdata;
                    default: shadow[8:11] <= ls_rdata;
                endcase
            end

            // The whole line swaps in one edge so fetch never sees a partial line.
            if (commit) begin
                ins_cache   <= {shadow, ls_rdata};
                line_valid  <= 1'b1;
                loaded_addr <= fill_addr;
            end
        end
    end
endmodule

// File: tb/tb_ins_line_fill.sv
// tb/tb_ins_line_fill.sv - directed self-checking bench for ins_line_fill
module tb_ins_line_fill;
    localparam int LS_QW_W = 14;
    localparam int PC_W    = 8;
`ifdef ILF_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset, read_enable, ls_gnt, ls_rvalid;
    logic [PC_W-1:0]    line_addr;
    logic [0:127]       ls_rdata;
    logic [0:15][0:31]  ins_cache;
    logic               line_valid, line_done, busy, ls_req;
    logic [LS_QW_W-1:0] ls_addr;

    logic               w_read_enable;
    logic [PC_W-1:0]    w_line_addr;
    logic [0:15][0:31]  w_ins_cache;
    logic               w_line_valid, w_line_done, w_busy, w_ls_req;
    logic [1:0]         w_ls_addr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    int q_addr[$];
    int q_due[$];

    int t0, rel, n_req, n_done, done_at;
    int req_log[8];
    logic [31:0] busy1, busy6, w15_pre;
    logic any_req, any_busy, any_done, any_valid, old_ok;

    always #5 clk = ~clk;

    ins_line_fill #(.LS_QW_W(LS_QW_W), .PC_W(PC_W)) u_dut (
        .clk(clk), .reset(reset), .read_enable(read_enable), .line_addr(line_addr),
        .ins_cache(ins_cache), .line_valid(line_valid), .line_done(line_done), .busy(busy),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata)
    );

    ins_line_fill #(.LS_QW_W(2), .PC_W(PC_W)) u_wrap (
        .clk(clk), .reset(reset), .read_enable(w_read_enable), .line_addr(w_line_addr),
        .ins_cache(w_ins_cache), .line_valid(w_line_valid), .line_done(w_line_done), .busy(w_busy),
        .ls_req(w_ls_req), .ls_addr(w_ls_addr), .ls_gnt(1'b1),
        .ls_rvalid(1'b0), .ls_rdata(128'd0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Quadword a carries instruction words 4a..4a+3, word 0 in the top bits.
    function automatic logic [0:127] mk_qw(input int a);
        logic [0:127] d;
        for (int j = 0; j < 4; j++) d[32*j +: 32] = 32'(4*a + j);
        return d;
    endfunction

    task automatic tick();
        if (ls_req && ls_gnt) begin
            q_addr.push_back(int'(ls_addr));
            q_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            ls_rvalid = 1'b1;
            ls_rdata  = mk_qw(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; read_enable = 1'b0; line_addr = '0; ls_gnt = 1'b0;
        ls_rvalid = 1'b0; ls_rdata = '0; w_read_enable = 1'b0; w_line_addr = '0;
        tick(); tick();

        check("rst_line_valid", 32'(line_valid), 32'd0);
        check("rst_line_done",  32'(line_done),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_ls_req",     32'(ls_req),     32'd0);
        check("rst_ls_addr",    32'(ls_addr),    32'd0);
        check("rst_word0",      ins_cache[0],    32'd0);
        check("rst_word15",     ins_cache[15],   32'd0);

        reset = 1'b1;
        tick();

        // Line 0, grant always, one-cycle LS latency.
        t0 = cyc; read_enable = 1'b1; line_addr = 8'h00; ls_gnt = 1'b1; lat = 1;
        n_req = 0; n_done = 0; done_at = -1;
        for (int i = 0; i < 10; i++) begin
            if (ls_req && ls_gnt) begin
                if (n_req < 8) req_log[n_req] = int'(ls_addr);
                n_req++;
            end
            tick();
            rel = cyc - t0;
            if (rel == 1) busy1 = 32'(busy);
            if (rel == 5) w15_pre = ins_cache[15];
            if (rel == 6) busy6 = 32'(busy);
            if (line_done) begin
                n_done++;
                if (done_at < 0) done_at = rel;
            end
        end
        check("t1_busy_cycle1", busy1, 32'd1);
        check("t1_n_req",       32'(n_req), 32'd4);
        for (int k = 0; k < 4; k++) check("t1_ls_addr", 32'(req_log[k]), 32'(k));
        check("t1_done_cycle",  32'(done_at), 32'd6);
        check("t1_done_pulses", 32'(n_done), 32'd1);
        check("t1_word15_pre",  w15_pre, 32'd0);
        check("t1_busy_cycle6", busy6, 32'd0);
        check("t1_word0",       ins_cache[0], 32'h0);
        check("t1_word15",      ins_cache[15], 32'hF);
        check("t1_line_valid",  32'(line_valid), 32'd1);

        // Held request on the same line (low address bits differ) must not refetch.
        line_addr = 8'h03; any_req = 1'b0; any_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ls_req) any_req = 1'b1;
            if (busy) any_busy = 1'b1;
            tick();
        end
        check("t2_no_req",  32'(any_req),  32'd0);
        check("t2_no_busy", 32'(any_busy), 32'd0);

        // Line 0x10: grant low for 3 cycles, 4-cycle response latency.
        t0 = cyc; read_enable = 1'b1; line_addr = 8'h10; ls_gnt = 1'b0; lat = 4;
        n_req = 0; done_at = -1; old_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (ls_req && ls_gnt) begin
                if (n_req < 8) req_log[n_req] = int'(ls_addr);
                n_req++;
            end
            tick();
            rel = cyc - t0;
            read_enable = 1'b0;
            ls_gnt = (rel >= 4);
            if (line_done && done_at < 0) done_at = rel;
            if (done_at < 0)
                for (int k = 0; k < 16; k++) if (ins_cache[k] !== 32'(k)) old_ok = 1'b0;
        end
        check("t3_done_cycle", 32'(done_at), 32'd12);
        check("t3_old_kept",   32'(old_ok), 32'd1);
        check("t3_n_req",      32'(n_req), 32'd4);
        for (int k = 0; k < 4; k++) check("t3_ls_addr", 32'(req_log[k]), 32'(4 + k));
        for (int k = 0; k < 16; k++) check("t3_word", ins_cache[k], 32'(16 + k));

        // Reset after two beats, then stray responses.
        ls_gnt = 1'b1; lat = 1; read_enable = 1'b1; line_addr = 8'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            read_enable = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("t4_busy",       32'(busy),       32'd0);
        check("t4_ls_req",     32'(ls_req),     32'd0);
        check("t4_ls_addr",    32'(ls_addr),    32'd0);
        check("t4_line_valid", 32'(line_valid), 32'd0);
        check("t4_line_done",  32'(line_done),  32'd0);
        check("t4_word0",      ins_cache[0],    32'd0);
        check("t4_word15",     ins_cache[15],   32'd0);
        q_addr.delete();
        q_due.delete();
        tick();
        reset = 1'b1;
        q_addr.push_back(10); q_due.push_back(cyc + 1);
        q_addr.push_back(11); q_due.push_back(cyc + 2);
        any_busy = 1'b0; any_done = 1'b0; any_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy) any_busy = 1'b1;
            if (line_done) any_done = 1'b1;
            if (line_valid) any_valid = 1'b1;
        end
        check("t4_stray_busy",  32'(any_busy),  32'd0);
        check("t4_stray_done",  32'(any_done),  32'd0);
        check("t4_stray_valid", 32'(any_valid), 32'd0);
        check("t4_stray_word0", ins_cache[0],   32'd0);

        // Requests 0x10 then 0x20 during the 0x10 fill.
        t0 = cyc; read_enable = 1'b1; line_addr = 8'h10; n_done = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            rel = cyc - t0;
            read_enable = (rel <= 2);
            line_addr = (rel == 2) ? 8'h20 : 8'h10;
            if (line_done) n_done++;
            if (rel == 6) begin
                check("t5_done_cycle6", 32'(line_done), 32'd1);
                check("t5_first_word0", ins_cache[0], 32'h10);
                check("t5_busy_cycle6", 32'(busy), 32'(PEND));
                check("t5_next_qw",     32'(ls_addr), PEND ? 32'd8 : 32'd0);
            end
        end
        check("t5_done_pulses", 32'(n_done), PEND ? 32'd2 : 32'd1);
        check("t5_final_word0", ins_cache[0], PEND ? 32'h20 : 32'h10);
        check("t5_final_word15", ins_cache[15], PEND ? 32'h2F : 32'h1F);
        check("t5_final_busy",  32'(busy), 32'd0);

        // Two-bit LS address space: quadword 3 wraps to 0.
        w_read_enable = 1'b1; w_line_addr = 8'h0C; n_req = 0;
        for (int i = 0; i < 8; i++) begin
            if (w_ls_req) begin
                if (n_req < 8) req_log[n_req] = int'(w_ls_addr);
                n_req++;
            end
            tick();
            w_read_enable = 1'b0;
        end
        check("t6_n_req",  32'(n_req), 32'd4);
        check("t6_addr0",  32'(req_log[0]), 32'd3);
        check("t6_addr1",  32'(req_log[1]), 32'd0);
        check("t6_addr2",  32'(req_log[2]), 32'd1);
        check("t6_addr3",  32'(req_log[3]), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ins_line_fill.md
# ins_line_fill

Instruction line fill unit: the producer side of the 64 B instruction line buffer consumed by instruction fetch. On a fetch request (`read_enable` with a line address) it reads four 16 B quadwords from local store and assembles them in a shadow buffer. It then atomically presents the 16×32-bit line on `ins_cache`. Fetch keeps reading the old line undisturbed until the swap.

## Interface
- `LS_QW_W`, 14: local-store quadword address width (256 KB LS).
- `PC_W`, 8: width of the instruction-word line address from fetch.
- `clk` in 1: clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `read_enable` in 1: fetch request, level, sampled every cycle.
- `line_addr` in PC_W: instruction-word address of the requested line; bits [1:0] ignored.
- `ins_cache` out 16×32 ([0:31] per word, index [0:15]): current instruction line.
- `line_valid` out 1: `ins_cache` holds a fetched line.
- `line_done` out 1: one-cycle pulse in the first cycle a new line is visible.
- `busy` out 1: fill in progress (state != IDLE).
- `ls_req` out 1, `ls_addr` out LS_QW_W: LS read request; quadword address.
- `ls_gnt` in 1: LS accepts the request this cycle.
- `ls_rvalid` in 1, `ls_rdata` in 128 ([0:127]): in-order read response.

## Operation
- States: IDLE, FILL.
- Registers: `issue_cnt[2:0]`, `rsp_cnt[2:0]`, `base_qw`, `loaded_addr`, `shadow[0:11]`.
- IDLE→FILL when `read_enable`=1 and (`line_valid`=0 or `line_addr[PC_W-1:2]` != `loaded_addr`). Held requests for the already-loaded line never refetch.
  - On that edge: `base_qw` = zero-extended `line_addr[PC_W-1:2]`, and both counters are cleared.
- FILL issue: `ls_req` = (`issue_cnt` < 4); `ls_addr` = (`base_qw` + `issue_cnt`) mod 2^LS_QW_W, so the address wraps at the top of LS. `issue_cnt` increments on `ls_req` & `ls_gnt`.
- FILL response: on `ls_rvalid`, beat k = `rsp_cnt` maps to `ins_cache[4k+j]` = `ls_rdata[32j +: 32]` for j=0..3, big-endian word order. Beats 0–2 go to `shadow`. `rsp_cnt` increments.
- Commit on the edge that accepts beat 3:
  - `ins_cache` ← `shadow` + beat 3, all 16 words together.
  - `line_valid`←1, `loaded_addr`←request address, `line_done` pulses.
  - FILL→IDLE, or directly FILL again if a pending request exists (see Configuration).
- `ls_rvalid` in IDLE, or with `rsp_cnt`=4, is ignored, e.g. stale responses after reset.
- Reset (async, any time, including mid-fill): state IDLE, counters 0, `ins_cache` all 0, `shadow` 0, `line_valid` 0, `line_done` 0, `busy` 0, `ls_req` 0, `ls_addr` 0, `loaded_addr` 0.

## Timing
- `read_enable` accepted in cycle 0. `busy`/`ls_req` are high from cycle 1 (registered state, combinational `ls_req`).
- With `ls_gnt`=1 and one-cycle LS latency: requests in cycles 1–4, responses in cycles 2–5. New `ins_cache`, `line_done`=1 and `busy`=0 all appear in cycle 6: latency 6 cycles.
- `ls_gnt` low stalls issue only; responses may lag grant by any number of cycles, in order. Up to 4 outstanding.
- `ins_cache` never changes except at commit or reset; no partial line is ever visible.
- A request in the commit cycle itself counts as "during fill".

## Configuration
- `ILF_PENDING_EN` defined: a one-deep pending slot.
  - `read_enable` during FILL with a line address differing from the in-flight one is latched; the last such request wins.
  - At commit, the unit re-enters FILL for the pending address if it differs from the just-committed line. Otherwise the slot is discarded.
- Undefined: `read_enable` during FILL is ignored; fetch must re-assert after `busy` falls.

## Test plan
- Reset release, `read_enable`=1, `line_addr`=0, LS returns words 0x00000000..0x0000000F → `ls_addr` 0,1,2,3. Cycle 6: `ins_cache[0]`=0x0, `ins_cache[15]`=0xF, `line_valid`=1, one `line_done` pulse.
- `read_enable` held high on `line_addr`=0 after commit → no further `ls_req`, `busy` stays 0.
- `line_addr`=0x10 with `ls_gnt` low for 3 cycles and 4-cycle response latency → `ins_cache` keeps the old line until the beat-3 edge, then all 16 words switch together.
- `LS_QW_W`=2, request addressing quadword 3 → `ls_addr` 3,0,1,2 (wrap).
- Reset asserted after 2 beats returned, then 2 stray `ls_rvalid` → all outputs 0, stray beats ignored, `line_valid`=0.
- With `ILF_PENDING_EN`: requests 0x10 then 0x20 during the 0x10 fill → 0x10 commits, second fill starts at quadword 8 the next cycle. Without the macro: no second fill.
